// File: rtl/cola_solicitudes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cola_solicitudes_pkg
//  Purpose  : Elevator request codes and small helpers shared by the request
//             queue and its consumers.
//  Revision : 1.0  initial release
// ============================================================================
package cola_solicitudes_pkg;

  localparam int NUM_BTN = 10;

  localparam logic [3:0] COD_NADA = 4'd0;
  localparam logic [3:0] COD_P1   = 4'd1;
  localparam logic [3:0] COD_P2   = 4'd2;
  localparam logic [3:0] COD_P3   = 4'd3;
  localparam logic [3:0] COD_P4   = 4'd4;
  localparam logic [3:0] COD_S1   = 4'd5;
  localparam logic [3:0] COD_B2   = 4'd6;
  localparam logic [3:0] COD_S2   = 4'd7;
  localparam logic [3:0] COD_B3   = 4'd8;
  localparam logic [3:0] COD_S3   = 4'd9;
  localparam logic [3:0] COD_B4   = 4'd10;

  // Lowest-numbered code whose bit is set (bit k-1 = code k); COD_NADA if none.
  function automatic logic [3:0] lowest_code(input logic [NUM_BTN-1:0] bits);
    lowest_code = COD_NADA;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (bits[i]) lowest_code = 4'(i + 1);
    end
  endfunction

  // One-hot bitmap for a code; all zeros for COD_NADA or an out-of-range code.
  function automatic logic [NUM_BTN-1:0] code_to_bit(input logic [3:0] code);
    code_to_bit = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      code_to_bit[i] = (code == 4'(i + 1));
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cola_solicitudes_antirrebote.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote
//  Purpose  : One call button: 2-FF synchroniser, debounce counter and
//             rising-edge press pulse on the accepted level.
//  Revision : 1.0  initial release
// ============================================================================
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles the synced level differs from the accepted one;
  // any return to the accepted level restarts the count. Accepting a 0->1
  // change emits a single press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/cola_solicitudes.sv
`default_nettype none
// ============================================================================
//  Module   : cola_solicitudes
//  Purpose  : Turns the 10 raw call buttons into an ordered, duplicate-free
//             queue of request codes 1..10 for the elevator state machine.
//  Revision : 1.0  initial release
// ============================================================================
module cola_solicitudes
  import cola_solicitudes_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piso1,
  input  logic       piso2,
  input  logic       piso3,
  input  logic       piso4,
  input  logic       S1,
  input  logic       B2,
  input  logic       S2,
  input  logic       B3,
  input  logic       S3,
  input  logic       B4,
  input  logic       req_ack,
  output logic       req_valid,
  output logic [3:0] req_code,
  output logic [4:0] req_count,
  output logic [9:0] pend_map
);

  localparam int PW = $clog2(DEPTH);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;

  logic [NUM_BTN-1:0] r_hold;
  logic [NUM_BTN-1:0] r_queued;
  logic [3:0]         r_mem [DEPTH];
  logic [PW-1:0]      r_rd;
  logic [PW-1:0]      r_wr;
  logic [4:0]         r_count;
  logic               r_req_valid;
  logic [3:0]         r_req_code;
  logic [NUM_BTN-1:0] r_pend;

  // Button position in the bitmaps is the button's code minus one.
  assign w_raw[COD_P1 - 4'd1] = piso1;
  assign w_raw[COD_P2 - 4'd1] = piso2;
  assign w_raw[COD_P3 - 4'd1] = piso3;
  assign w_raw[COD_P4 - 4'd1] = piso4;
  assign w_raw[COD_S1 - 4'd1] = S1;
  assign w_raw[COD_B2 - 4'd1] = B2;
  assign w_raw[COD_S2 - 4'd1] = S2;
  assign w_raw[COD_B3 - 4'd1] = B3;
  assign w_raw[COD_S3 - 4'd1] = S3;
  assign w_raw[COD_B4 - 4'd1] = B4;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk    (clk),
      .rst    (rst),
      .in_raw (w_raw[gi]),
      .level  (w_level[gi]),
      .press  (w_press[gi])
    );
  end

  // Pop, push and next-state bookkeeping for the hold/queued maps and FIFO.
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic [3:0]         w_push_code;
  logic [NUM_BTN-1:0] w_push_bit;
  logic [NUM_BTN-1:0] w_pop_bit;
  logic [NUM_BTN-1:0] w_pend;
  logic [NUM_BTN-1:0] w_new_press;
  logic [NUM_BTN-1:0] w_hold_next;
  logic [NUM_BTN-1:0] w_queued_next;
  logic [4:0]         w_count_next;
  logic [PW-1:0]      w_rd_next;
  logic [PW-1:0]      w_wr_next;
  logic [3:0]         w_head_next;

  assign w_pop         = req_ack && (r_count != 5'd0);
  assign w_full        = (r_count == 5'(DEPTH));
  assign w_push        = (r_hold != '0) && (!w_full || w_pop);
  assign w_push_code   = lowest_code(r_hold);
  assign w_push_bit    = w_push ? code_to_bit(w_push_code) : '0;
  assign w_pop_bit     = w_pop ? code_to_bit(r_mem[r_rd]) : '0;
  assign w_pend        = r_hold | r_queued;
  // A press is honoured only while its accepted level is high, and only
  // when the code is neither waiting in hold nor already queued.
  assign w_new_press   = w_press & w_level & ~w_pend;
  assign w_hold_next   = (r_hold & ~w_push_bit) | w_new_press;
  assign w_queued_next = (r_queued & ~w_pop_bit) | w_push_bit;
  assign w_count_next  = r_count + {4'd0, w_push} - {4'd0, w_pop};
  assign w_rd_next     = w_pop  ? r_rd + 1'b1 : r_rd;
  assign w_wr_next     = w_push ? r_wr + 1'b1 : r_wr;

  // Next head: a slot written this cycle is not yet in the array, so take
  // the pushed code directly when it lands at the new read pointer.
  always_comb begin
    w_head_next = COD_NADA;
    if (w_count_next != 5'd0) begin
      if (w_push && (r_wr == w_rd_next)) begin
        w_head_next = w_push_code;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  // Queue state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_queued    <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= 5'd0;
      r_req_valid <= 1'b0;
      r_req_code  <= COD_NADA;
      r_pend      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= COD_NADA;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_push_code;
      end
      r_hold      <= w_hold_next;
      r_queued    <= w_queued_next;
      r_rd        <= w_rd_next;
      r_wr        <= w_wr_next;
      r_count     <= w_count_next;
      r_req_valid <= (w_count_next != 5'd0);
      r_req_code  <= w_head_next;
      r_pend      <= w_hold_next | w_queued_next;
    end
  end

  assign req_valid = r_req_valid;
  assign req_code  = r_req_code;
  assign req_count = r_count;
  assign pend_map  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_cola_solicitudes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cola_solicitudes
//  Purpose  : Self-checking bench for cola_solicitudes with a queue-based
//             reference model and directed plus random button stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cola_solicitudes;

  localparam int DEPTH = 4;
  localparam int DEB   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] raw = '0;
  logic       ack = 1'b0;

  logic       req_valid;
  logic [3:0] req_code;
  logic [4:0] req_count;
  logic [9:0] pend_map;

  int n_vec = 0;
  int n_err = 0;

  cola_solicitudes #(
    .DEPTH           (DEPTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .piso1     (raw[0]),
    .piso2     (raw[1]),
    .piso3     (raw[2]),
    .piso4     (raw[3]),
    .S1        (raw[4]),
    .B2        (raw[5]),
    .S2        (raw[6]),
    .B3        (raw[7]),
    .S3        (raw[8]),
    .B4        (raw[9]),
    .req_ack   (ack),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_count (req_count),
    .pend_map  (pend_map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_rh[i] = raw buttons as seen at the clock edge i edges ago.
  logic [9:0] m_rh [0:DEB+1];
  logic [9:0] m_level;
  logic [9:0] m_press;
  logic [9:0] m_hold;
  logic [3:0] m_q[$];

  function automatic logic [9:0] m_members();
    logic [9:0] b = '0;
    foreach (m_q[i]) b[m_q[i] - 4'd1] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hold  = '0;
    m_level = '0;
    m_press = '0;
    for (int i = 0; i <= DEB + 1; i++) m_rh[i] = '0;
  endtask

  task automatic model_step(input logic [9:0] r, input logic a);
    logic [9:0] pend_old;
    logic [9:0] new_hold;
    logic [9:0] new_level;
    bit         pop;
    bit         push;
    int         ci;
    bit         all1;
    bit         all0;
    pend_old = m_hold | m_members();
    pop      = a && (m_q.size() > 0);
    push     = (m_hold != 0) && ((m_q.size() < DEPTH) || pop);
    new_hold = m_hold;
    ci       = 0;
    if (push) begin
      for (int i = 9; i >= 0; i--) if (m_hold[i]) ci = i + 1;
      new_hold[ci-1] = 1'b0;
    end
    new_hold = new_hold | (m_press & ~pend_old);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(4'(ci));
    m_hold = new_hold;
    // Button path: accepted level flips once the last DEB synced samples
    // (raw delayed by two edges) all agree on a value.
    for (int i = DEB + 1; i > 0; i--) m_rh[i] = m_rh[i-1];
    m_rh[0] = r;
    for (int b = 0; b < 10; b++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (m_rh[2+j][b])  all0 = 1'b0;
        if (!m_rh[2+j][b]) all1 = 1'b0;
      end
      new_level[b] = all1 ? 1'b1 : (all0 ? 1'b0 : m_level[b]);
    end
    m_press = new_level & ~m_level;
    m_level = new_level;
  endtask

  // Compare process: inputs change at negedge+1, so at each negedge they
  // still hold the values sampled at the preceding rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      else      model_step(raw, ack);
      chk("valid", int'(req_valid), int'(m_q.size() > 0));
      chk("code",  int'(req_code),  (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("count", int'(req_count), m_q.size());
      chk("pend",  int'(pend_map),  int'(m_hold | m_members()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  int lat;

  initial begin
    cyc(3);
    rst = 1'b1;
    cyc(5);
    chk("reset_count", int'(req_count), 0);

    // 1: single press latency and outputs
    raw[6] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (req_valid && lat == 0) begin
        lat = k;
        chk("t1_code", int'(req_code), 7);
        chk("t1_count", int'(req_count), 1);
        chk("t1_pend", int'(pend_map), int'(10'b0001000000));
      end
    end
    #1;
    raw[6] = 1'b0;
    chk("t1_latency", lat, 8);
    pulse_ack();
    cyc(3);
    chk("t1_drained", int'(req_count), 0);

    // 2: bouncing piso3, then a duplicate press while queued
    raw[2] = 1'b1; cyc(2); raw[2] = 1'b0; cyc(2);
    raw[2] = 1'b1; cyc(2); raw[2] = 1'b0; cyc(2);
    raw[2] = 1'b1; cyc(12);
    chk("t2_count", int'(req_count), 1);
    chk("t2_code", int'(req_code), 3);
    raw[2] = 1'b0; cyc(8);
    raw[2] = 1'b1; cyc(12);
    chk("t2_dup_count", int'(req_count), 1);
    raw[2] = 1'b0;
    pulse_ack();
    cyc(8);

    // 3: simultaneous presses enter in ascending order
    raw[3] = 1'b1; raw[4] = 1'b1; raw[7] = 1'b1;
    cyc(8);
    chk("t3_count1", int'(req_count), 1);
    chk("t3_head", int'(req_code), 4);
    cyc(1);
    chk("t3_count2", int'(req_count), 2);
    cyc(1);
    chk("t3_count3", int'(req_count), 3);
    raw[3] = 1'b0; raw[4] = 1'b0; raw[7] = 1'b0;
    pulse_ack();
    chk("t3_pop5", int'(req_code), 5);
    pulse_ack();
    chk("t3_pop8", int'(req_code), 8);
    pulse_ack();
    chk("t3_empty", int'(req_code), 0);
    cyc(8);

    // 4: full queue, B4 waits in hold, push+pop when full
    raw[3:0] = 4'hF; cyc(12); raw[3:0] = 4'h0;
    chk("t4_full", int'(req_count), 4);
    raw[9] = 1'b1; cyc(12);
    chk("t4_hold_pend", int'(pend_map), int'(10'b1000001111));
    chk("t4_count", int'(req_count), 4);
    pulse_ack();
    chk("t4_count_after", int'(req_count), 4);
    chk("t4_head_after", int'(req_code), 2);
    chk("t4_pend_after", int'(pend_map), int'(10'b1000001110));
    raw[9] = 1'b0;
    repeat (4) pulse_ack();
    chk("t4_drained", int'(req_count), 0);
    cyc(8);

    // 5: ack while empty; push and pop together at count=1
    pulse_ack();
    chk("t5_empty_ack", int'(req_count), 0);
    raw[5] = 1'b1; cyc(10);
    chk("t5_b2_code", int'(req_code), 6);
    raw[5] = 1'b0; cyc(8);
    raw[8] = 1'b1; cyc(7);
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("t5_count", int'(req_count), 1);
    chk("t5_head", int'(req_code), 9);
    raw[8] = 1'b0;
    pulse_ack();
    cyc(8);

    // 6: asynchronous reset mid-operation, held button re-enqueues
    raw[3:0] = 4'hF; cyc(12); raw[3:0] = 4'h0;
    raw[9] = 1'b1; cyc(10);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", int'(req_valid), 0);
    chk("t6_rst_count", int'(req_count), 0);
    chk("t6_rst_pend", int'(pend_map), 0);
    chk("t6_rst_code", int'(req_code), 0);
    cyc(2);
    rst = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (req_valid && lat == 0) begin
        lat = k;
        chk("t6_code", int'(req_code), 10);
      end
    end
    #1;
    chk("t6_latency", lat, 8);
    raw[9] = 1'b0;
    pulse_ack();
    cyc(8);

    // Random phase: busy buttons with sparse acks, then sparse buttons
    // with frequent acks; one reset pulse in the middle.
    for (int it = 0; it < 3000; it++) begin
      if (it < 1500) begin
        if ($urandom_range(0, 3) == 0) raw[$urandom_range(0, 9)] ^= 1'b1;
        ack = ($urandom_range(0, 15) == 0);
      end else begin
        if ($urandom_range(0, 11) == 0) raw[$urandom_range(0, 9)] ^= 1'b1;
        ack = ($urandom_range(0, 3) == 0);
      end
      if (it == 1000) rst = 1'b0;
      if (it == 1002) rst = 1'b1;
      cyc(1);
    end
    ack = 1'b0;
    raw = '0;
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
